shift_seq: RTL

Multi-bit shift sequencer for the lab1 ALU datapath. Accepts a 16-bit operand, a shift function code and a shift amount over a valid/ready handshake. Produces the multi-bit result by iterating the single-bit SHIFT unit once per clock. The block feeds SHIFT its operand and function code, consumes SHIFT's result each cycle, and delivers the final value downstream over a second valid/ready handshake.

---
 rtl/shift_seq_if.sv | 31 +++
 rtl/shift_seq.sv | 88 ++++++++
 2 files changed

// File: rtl/shift_seq_if.sv
// Handshake and SHIFT-unit bus for the multi-bit shift sequencer.
// slave is the sequencer side; master is the requester/consumer/SHIFT side.
interface shift_seq_if #(
  parameter int data_width = 16,
  parameter int amt_width  = 4
);
  // Request channel
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] in_a;
  logic [3:0]            in_func;
  logic [amt_width-1:0]  in_amt;
  // Single-bit SHIFT unit connection
  logic [data_width-1:0] shift_a;
  logic [3:0]            shift_func;
  logic [data_width-1:0] shift_c;
  // Result channel
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_c;

  modport slave (
    input  in_valid, in_a, in_func, in_amt, shift_c, out_ready,
    output in_ready, shift_a, shift_func, out_valid, out_c
  );

  modport master (
    output in_valid, in_a, in_func, in_amt, shift_c, out_ready,
    input  in_ready, shift_a, shift_func, out_valid, out_c
  );
endinterface

// File: rtl/shift_seq.sv
// Multi-bit shift sequencer: iterates the external single-bit SHIFT unit
// once per clock, cnt times, then offers the result downstream.
module shift_seq #(
  parameter int data_width = 16,
  parameter int amt_width  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  shift_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] acc_q, acc_d;
  logic [3:0]            func_q, func_d;
  logic [amt_width-1:0]  cnt_q, cnt_d;

  // Outputs come straight from state; no path from in_* to out_*.
  assign bus.shift_a    = acc_q;
  assign bus.shift_func = func_q;
  assign bus.out_c      = acc_q;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.in_ready   = (state_q == IDLE) & reset_n;

  // Next-state and datapath update for accept / iterate / hand-off.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    func_d  = func_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Reset is handled in the register block, so in_valid alone
        // qualifies acceptance here.
        if (bus.in_valid) begin
          acc_d   = bus.in_a;
          func_d  = bus.in_func;
          cnt_d   = bus.in_amt;
          state_d = (bus.in_amt == {amt_width{1'b0}}) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // SHIFT result is combinational off acc, so each edge applies one bit.
        acc_d = bus.shift_c;
        cnt_d = cnt_q - amt_width'(1);
        if (cnt_q == amt_width'(1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        // Hold acc; new requests wait until the result is taken.
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= {data_width{1'b0}};
      func_q  <= 4'b0000;
      cnt_q   <= {amt_width{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
